// File: rtl/ddc_decim_rs.sv
// Decimate-by-R, round/saturate to DOUT_W, and buffer in a small output FIFO.
// Sticky flags report saturated kept samples and samples dropped on a full FIFO.
module ddc_decim_rs #(
  parameter int DIN_W      = 29,
  parameter int DOUT_W     = 16,
  parameter int SHIFT      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  input  logic [7:0]        dec_ratio,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sat_flag,
  output logic              ovf_flag,
  input  logic              flag_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = DIN_W + 1 - SHIFT;
  localparam logic [DIN_W:0] RND = {{(DIN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic [7:0] phase;
  logic [7:0] reff;
  logic [7:0] reff_m1;
  logic       keep;

  // A ratio change that leaves phase past the new terminal count keeps the next sample.
  always_comb begin
    reff    = (dec_ratio == 8'd0) ? 8'd1 : dec_ratio;
    reff_m1 = reff - 8'd1;
    keep    = din_valid && (phase >= reff_m1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 8'd0;
    end else if (din_valid) begin
      phase <= keep ? 8'd0 : phase + 8'd1;
    end
  end

  logic [DIN_W:0] s1;
  logic           s1_v;
  logic           s1_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else begin
      s1_v <= keep;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      s1 <= {din[DIN_W-1], din} + RND;
    end
  end

  assign s1_unused = ^s1[SHIFT-1:0];

  logic [TW-1:0]       t;
  logic [TW-DOUT_W:0]  t_upper;
  logic                fits;
  logic [DOUT_W-1:0]   s2_next;
  logic [DOUT_W-1:0]   s2;
  logic                s2_v;
  logic                sat_event;

  // t fits the output when all bits above the output sign bit match it.
  always_comb begin
    t       = s1[DIN_W:SHIFT];
    t_upper = t[TW-1:DOUT_W-1];
    fits    = (&t_upper) | ~(|t_upper);
    if (fits) begin
      s2_next = t[DOUT_W-1:0];
    end else if (t[TW-1]) begin
      s2_next = {1'b1, {(DOUT_W-1){1'b0}}};
    end else begin
      s2_next = {1'b0, {(DOUT_W-1){1'b1}}};
    end
    sat_event = s1_v && !fits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else begin
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_v) begin
      s2 <= s2_next;
    end
  end

  logic [DOUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop;
  logic              push;
  logic              ovf_event;

  // A full FIFO still accepts a write when the head is popped on the same edge.
  always_comb begin
    full       = (count == (AW+1)'(FIFO_DEPTH));
    dout_valid = (count != '0);
    pop        = dout_valid && dout_ready;
    push       = s2_v && (!full || pop);
    ovf_event  = s2_v && full && !pop;
    dout       = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (sat_event) begin
        sat_flag <= 1'b1;
      end else if (flag_clr) begin
        sat_flag <= 1'b0;
      end
      if (ovf_event) begin
        ovf_flag <= 1'b1;
      end else if (flag_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddc_decim_rs.sv
// Directed bench for ddc_decim_rs: rounding/saturation table, decimation,
// FIFO overflow, full-with-pop and mid-stream reset sequences.
module tb_ddc_decim_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] din;
  logic        din_valid;
  logic [7:0]  dec_ratio;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        sat_flag;
  logic        ovf_flag;
  logic        flag_clr;

  int checks = 0;
  int errors = 0;
  int got[$];

  typedef struct {
    int         din;
    logic [7:0] r;
    int         exp_dout;
    int         exp_sat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ddc_decim_rs dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dec_ratio  (dec_ratio),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .flag_clr   (flag_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int value, input logic [7:0] r);
    din       = value[28:0];
    dec_ratio = r;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic capture();
    if (dout_valid && dout_ready) got.push_back(int'($signed(dout)));
  endtask

  task automatic checkQueue(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
    int exp_q[4];
    int act;
    exp_q = '{e0, e1, e2, e3};
    checkOutput({name, "_len"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      act = (i < got.size()) ? got[i] : 32'h7fff_ffff;
      checkOutput($sformatf("%s_%0d", name, i), act, exp_q[i]);
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    flag_clr   = 1'b0;
    tick();
    tick();
    checkOutput("rst_dout", int'($signed(dout)), 0);
    checkOutput("rst_valid", int'(dout_valid), 0);
    checkOutput("rst_sat", int'(sat_flag), 0);
    checkOutput("rst_ovf", int'(ovf_flag), 0);
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    vecs[0] = '{din: 4096,       r: 8'd1, exp_dout: 1,      exp_sat: 0};
    vecs[1] = '{din: -4096,      r: 8'd1, exp_dout: 0,      exp_sat: 0};
    vecs[2] = '{din: 8191,       r: 8'd1, exp_dout: 1,      exp_sat: 0};
    vecs[3] = '{din: -12288,     r: 8'd1, exp_dout: -1,     exp_sat: 0};
    vecs[4] = '{din: 3*8192,     r: 8'd0, exp_dout: 3,      exp_sat: 0};
    vecs[5] = '{din: -5*8192,    r: 8'd0, exp_dout: -5,     exp_sat: 0};
    vecs[6] = '{din: 268435455,  r: 8'd1, exp_dout: 32767,  exp_sat: 1};
    vecs[7] = '{din: -268435456, r: 8'd1, exp_dout: -32768, exp_sat: 1};

    din        = '0;
    din_valid  = 1'b0;
    dec_ratio  = 8'd1;
    dout_ready = 1'b1;
    flag_clr   = 1'b0;
    rst        = 1'b1;
    doReset();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].din, vecs[i].r);
      checkOutput($sformatf("v%0d_lat1", i), int'(dout_valid), 0);
      tick();
      checkOutput($sformatf("v%0d_lat2", i), int'(dout_valid), 0);
      tick();
      checkOutput($sformatf("v%0d_valid", i), int'(dout_valid), 1);
      checkOutput($sformatf("v%0d_dout", i), int'($signed(dout)), vecs[i].exp_dout);
      checkOutput($sformatf("v%0d_sat", i), int'(sat_flag), vecs[i].exp_sat);
      tick();
      checkOutput($sformatf("v%0d_popped", i), int'(dout_valid), 0);
    end

    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("sat_cleared", int'(sat_flag), 0);

    // Saturation event on the same edge as flag_clr: set wins.
    applyStimulus(268435455, 8'd1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("sat_set_wins", int'(sat_flag), 1);
    for (int i = 0; i < 4; i++) tick();

    doReset();
    dout_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      capture();
      din       = 29'(k * 8192);
      dec_ratio = 8'd4;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      capture();
      tick();
    end
    checkQueue("dec4", 3, 4, 8, 12, 0);

    doReset();
    for (int k = 1; k <= 9; k++) begin
      capture();
      din       = 29'(k * 8192);
      dec_ratio = (k <= 5) ? 8'd4 : 8'd2;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      capture();
      tick();
    end
    checkQueue("rchg", 3, 4, 6, 8, 0);

    doReset();
    dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      din       = 29'(k * 8192);
      dec_ratio = 8'd1;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("ovf_flag", int'(ovf_flag), 1);
    checkOutput("ovf_head", int'($signed(dout)), 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture();
      tick();
    end
    checkQueue("ovf_drain", 4, 1, 2, 3, 4);
    checkOutput("ovf_empty", int'(dout_valid), 0);

    doReset();
    dout_ready = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(k * 8192, 8'd1);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("fp_head", int'($signed(dout)), 1);
    applyStimulus(5 * 8192, 8'd1);
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checkOutput("fp_ovf", int'(ovf_flag), 0);
    checkOutput("fp_head2", int'($signed(dout)), 2);
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture();
      tick();
    end
    checkQueue("fp_drain", 4, 2, 3, 4, 5);
    checkOutput("fp_empty", int'(dout_valid), 0);

    doReset();
    dout_ready = 1'b0;
    applyStimulus(268435455, 8'd1);
    applyStimulus(7 * 8192, 8'd1);
    tick();
    tick();
    checkOutput("mr_pre_sat", int'(sat_flag), 1);
    checkOutput("mr_pre_valid", int'(dout_valid), 1);
    applyStimulus(9 * 8192, 8'd1);
    rst = 1'b1;
    tick();
    checkOutput("mr_valid", int'(dout_valid), 0);
    checkOutput("mr_sat", int'(sat_flag), 0);
    checkOutput("mr_ovf", int'(ovf_flag), 0);
    checkOutput("mr_dout", int'($signed(dout)), 0);
    rst = 1'b0;
    got.delete();
    dout_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      capture();
      din       = 29'(k * 8192);
      dec_ratio = 8'd3;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      capture();
      tick();
    end
    checkQueue("mr_r3", 2, 3, 6, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
